// File: rtl/nbit_rr_mux_reg.sv
// nbit_rr_mux_reg: M-input, N-bit registered multiplexer with a valid/ready
// handshake on both sides. An internal arbiter (round-robin or fixed
// priority) picks one requesting channel per load. The picked word is held
// in a one-entry output register until the consumer takes it.
module nbit_rr_mux_reg #(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter bit PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M*N-1:0]       in_data,
  input  logic [M-1:0]         in_valid,
  output logic [M-1:0]         in_ready,
  output logic [N-1:0]         out_data,
  output logic [$clog2(M)-1:0] out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int SEL_W = $clog2(M);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] idx_sel;
  logic             found;
  logic             any_valid;
  logic             load;
  logic             fire;
  logic [N-1:0]     sel_data;
  int               idx;

  // The register can accept a word when it is empty or drained this cycle.
  assign any_valid = |in_valid;
  assign load      = ~out_valid | out_ready;

  // Arbiter: first requesting channel scanning from ptr (or from 0 when fixed).
  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    idx_sel = '0;
    for (int k = 0; k < M; k++) begin
      idx = PRIO ? k : int'(ptr) + k;
      if (idx >= M) idx = idx - M;
      idx_sel = SEL_W'(idx);
      if (!found && in_valid[idx_sel]) begin
        win   = idx_sel;
        found = 1'b1;
      end
    end
  end

  // Grant the winner only; never grant a channel that is not offering a word.
  always_comb begin
    in_ready = '0;
    if (load && any_valid && !rst) in_ready[win] = 1'b1;
  end

  assign fire     = |(in_valid & in_ready);
  assign sel_data = in_data[int'(win)*N +: N];

  // Output register and round-robin pointer; a load may coincide with a drain.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (fire) begin
        out_data  <= sel_data;
        out_sel   <= win;
        out_valid <= 1'b1;
        if (!PRIO) ptr <= (win == SEL_W'(M - 1)) ? '0 : win + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nbit_rr_mux_reg.sv
// Self-checking bench for nbit_rr_mux_reg: a round-robin instance and a
// fixed-priority instance share stimulus; each is tracked by a behavioural
// model that picks the requester closest (in rotation order) to the pointer.
module tb_nbit_rr_mux_reg;

  localparam int N = 32;
  localparam int M = 4;
  localparam int SEL_W = $clog2(M);

  logic             clk = 1'b0;
  logic             rst;
  logic [M*N-1:0]   in_data;
  logic [M-1:0]     in_valid;
  logic             out_ready;

  logic [M-1:0]     in_ready,  in_ready_p;
  logic [N-1:0]     out_data,  out_data_p;
  logic [SEL_W-1:0] out_sel,   out_sel_p;
  logic             out_valid, out_valid_p;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  bit           m_valid [2];
  logic [N-1:0] m_data  [2];
  int           m_sel   [2];
  int           m_ptr   [2];

  always #5 clk = ~clk;

  nbit_rr_mux_reg #(.N(N), .M(M), .PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  nbit_rr_mux_reg #(.N(N), .M(M), .PRIO(1'b1)) dut_p (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_p), .out_data(out_data_p), .out_sel(out_sel_p),
    .out_valid(out_valid_p), .out_ready(out_ready)
  );

  // Requesting channel with the smallest rotation distance from p wins.
  function automatic int model_winner(logic [M-1:0] v, int p, bit prio);
    int best = -1;
    int best_d = M;
    for (int i = 0; i < M; i++) begin
      int d;
      d = prio ? i : (i - p + M) % M;
      if (v[i] && d < best_d) begin
        best   = i;
        best_d = d;
      end
    end
    return best;
  endfunction

  function automatic logic [M-1:0] exp_ready(int inst);
    int w;
    bit can_load;
    if (rst) return '0;
    can_load = !m_valid[inst] || out_ready;
    w = model_winner(in_valid, m_ptr[inst], inst == 1);
    if (can_load && w >= 0) return M'(1) << w;
    return '0;
  endfunction

  function automatic logic [N-1:0] word(int ch);
    return in_data[ch*N +: N];
  endfunction

  // Advance one clock edge, update both models from the pre-edge inputs.
  task automatic tick();
    @(posedge clk);
    for (int inst = 0; inst < 2; inst++) begin
      int w;
      if (rst) begin
        m_valid[inst] = 1'b0;
        m_data[inst]  = '0;
        m_sel[inst]   = 0;
        m_ptr[inst]   = 0;
      end else begin
        w = model_winner(in_valid, m_ptr[inst], inst == 1);
        if ((!m_valid[inst] || out_ready) && w >= 0) begin
          m_valid[inst] = 1'b1;
          m_data[inst]  = word(w);
          m_sel[inst]   = w;
          if (inst == 0) m_ptr[inst] = (w + 1) % M;
        end else if (m_valid[inst] && out_ready) begin
          m_valid[inst] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic set_idx_data();
    for (int i = 0; i < M; i++) in_data[i*N +: N] = N'(32'h11 * i);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; set_idx_data();
    tick(); tick();
    tests_run++;
    if (in_ready !== 4'b0000 || in_ready_p !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b/%b want 0000", in_ready, in_ready_p);
    end
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%0d want v=0 d=0 s=0", out_valid, out_data, out_sel);
    end
    rst = 1'b0; #1;
    tests_run++;
    if (in_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL reset_first_grant: got %b want 0001", in_ready);
    end
  endtask

  task automatic test_rr_fair();
    for (int k = 0; k < 6; k++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_sel !== SEL_W'(k % M) || out_data !== N'(32'h11 * (k % M))) begin
        tests_failed++;
        $display("FAIL rr_fair[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", k, out_valid, out_sel, out_data, k % M, 32'h11 * (k % M));
      end
      tests_run++;
      if (in_ready !== M'(1) << ((k + 1) % M) || out_sel_p !== '0) begin
        tests_failed++;
        $display("FAIL rr_fair_ready[%0d]: got rdy=%b prio_sel=%0d want rdy=%b prio_sel=0", k, in_ready, out_sel_p, M'(1) << ((k + 1) % M));
      end
    end
  endtask

  task automatic test_backpressure();
    in_data[2*N +: N] = 32'hDEADBEEF;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_sel !== 2'd2) begin
        tests_failed++;
        $display("FAIL backpressure[%0d]: got rdy=%b v=%b d=%h s=%0d want rdy=0000 v=1 d=deadbeef s=2", k, in_ready, out_valid, out_data, out_sel);
      end
      tick();
    end
    out_ready = 1'b1; #1;
    tests_run++;
    if (in_ready !== 4'b1000) begin
      tests_failed++;
      $display("FAIL backpressure_release: got rdy=%b want 1000", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 32'h33) begin
      tests_failed++;
      $display("FAIL backpressure_reload: got v=%b s=%0d d=%h want v=1 s=3 d=33", out_valid, out_sel, out_data);
    end
    set_idx_data();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    in_valid = 4'b0100; tick();   // ch2 taken, pointer moves to 3
    in_valid = 4'b0010; #1;
    tests_run++;
    if (in_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL wrap_skip_ready: got %b want 0010", in_ready);
    end
    tick();
    tests_run++;
    if (out_sel !== 2'd1 || out_data !== 32'h11) begin
      tests_failed++;
      $display("FAIL wrap_skip_load: got s=%0d d=%h want s=1 d=11", out_sel, out_data);
    end
    in_valid = 4'b1001; #1;       // pointer is 2: scan 2,3 -> ch3
    tests_run++;
    if (in_ready !== 4'b1000) begin
      tests_failed++;
      $display("FAIL wrap_scan_ready: got %b want 1000", in_ready);
    end
    tick();
    in_valid = 4'b0101; #1;       // pointer wrapped to 0 -> ch0
    tests_run++;
    if (in_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL wrap_zero_ready: got %b want 0001", in_ready);
    end
    tick();
  endtask

  task automatic test_prio();
    in_valid = 4'b1010; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      tests_run++;
      if (out_valid_p !== 1'b1 || out_sel_p !== 2'd1 || in_ready_p !== 4'b0010) begin
        tests_failed++;
        $display("FAIL prio[%0d]: got v=%b s=%0d rdy=%b want v=1 s=1 rdy=0010", k, out_valid_p, out_sel_p, in_ready_p);
      end
    end
  endtask

  task automatic test_drain();
    in_valid = 4'b0000; out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || out_valid_p !== 1'b0 || in_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL drain: got v=%b/%b rdy=%b want v=0/0 rdy=0000", out_valid, out_valid_p, in_ready);
    end
    tests_run++;
    if (out_data_p !== 32'h11 || out_sel_p !== 2'd1) begin
      tests_failed++;
      $display("FAIL drain_keep: got d=%h s=%0d want d=11 s=1", out_data_p, out_sel_p);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b1111; out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    rst = 1'b1; #1;
    tests_run++;
    if (in_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_mid_ready: got %b want 0000", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got v=%b d=%h s=%0d want v=0 d=0 s=0", out_valid, out_data, out_sel);
    end
    rst = 1'b0; out_ready = 1'b1; #1;
    tests_run++;
    if (in_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL reset_mid_ptr: got %b want 0001", in_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(31) == 0);
      in_valid  = M'($urandom);
      out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < M; i++) in_data[i*N +: N] = N'($urandom);
      #1;
      tests_run++;
      if (in_ready !== exp_ready(0) || in_ready_p !== exp_ready(1)) begin
        tests_failed++;
        $display("FAIL rand_ready[%0d]: got %b/%b want %b/%b", c, in_ready, in_ready_p, exp_ready(0), exp_ready(1));
      end
      tick();
      tests_run++;
      if (out_valid !== m_valid[0] || out_data !== m_data[0] || out_sel !== SEL_W'(m_sel[0])) begin
        tests_failed++;
        $display("FAIL rand_rr[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", c, out_valid, out_data, out_sel, m_valid[0], m_data[0], m_sel[0]);
      end
      tests_run++;
      if (out_valid_p !== m_valid[1] || out_data_p !== m_data[1] || out_sel_p !== SEL_W'(m_sel[1])) begin
        tests_failed++;
        $display("FAIL rand_prio[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", c, out_valid_p, out_data_p, out_sel_p, m_valid[1], m_data[1], m_sel[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fair();
    test_backpressure();
    test_wrap();
    test_prio();
    test_drain();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
